// File: rtl/oldland_bus_pkg.sv
// rtl/oldland_bus_pkg.sv - shared data-bus state encoding and byte-select helpers
package oldland_bus_pkg;

  // Responder handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  // Byte, halfword and word lane patterns the bus accepts
  localparam logic [3:0] BSEL_B0 = 4'b0001;
  localparam logic [3:0] BSEL_B1 = 4'b0010;
  localparam logic [3:0] BSEL_B2 = 4'b0100;
  localparam logic [3:0] BSEL_B3 = 4'b1000;
  localparam logic [3:0] BSEL_H0 = 4'b0011;
  localparam logic [3:0] BSEL_H1 = 4'b1100;
  localparam logic [3:0] BSEL_W  = 4'b1111;

  // True when the lane pattern is an aligned byte, halfword or full word
  function automatic logic bytesel_legal(input logic [3:0] bsel);
    case (bsel)
      BSEL_B0, BSEL_B1, BSEL_B2, BSEL_B3,
      BSEL_H0, BSEL_H1, BSEL_W: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  // Expand lane enables into a 32-bit data mask
  function automatic logic [31:0] lane_mask(input logic [3:0] bsel);
    return {{8{bsel[3]}}, {8{bsel[2]}}, {8{bsel[1]}}, {8{bsel[0]}}};
  endfunction

endpackage

// File: rtl/oldland_dbus_ram.sv
// rtl/oldland_dbus_ram.sv - single-port word RAM with byte write enables and registered read
module oldland_dbus_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Lane-masked write and registered read on the same address; no reset so it maps to block RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/oldland_dbus_responder.sv
// rtl/oldland_dbus_responder.sv - data-bus target: request FSM, wait states and RAM backing
module oldland_dbus_responder
  import oldland_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [3:0]  bus_bytesel,
  input  logic        bus_wr_en,
  input  logic [31:0] bus_wr_val,
  input  logic        bus_access,
  output logic [31:0] bus_data,
  output logic        bus_ack,
  output logic        bus_error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_state_e     state_q;
  logic [3:0]     cnt_q;
  logic           ack_q;
  logic           err_q;
  logic [31:0]    data_q;

  logic [AW-1:0]  idx_q;
  logic [3:0]     bsel_q;
  logic           wr_q;
  logic [31:0]    wval_q;
  logic           bad_q;

  // Offset from the window base; an address below the base wraps high and fails the range test
  logic [31:0]    req_off;
  logic           req_bad;
  logic [AW-1:0]  req_idx;
  logic [AW-1:0]  ram_idx;
  logic [3:0]     ram_we;
  logic [31:0]    ram_rdata;
  logic [31:0]    load_word;
  logic           load_resp;

  assign req_off = bus_addr - ADDR_BASE;
  assign req_bad = (req_off >= SPAN_BYTES) || !bytesel_legal(bus_bytesel);
  assign req_idx = req_off[AW+1:2];

  // Reading from the live address in IDLE lets a zero-wait load return data in the very next cycle
  assign ram_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
  // rst_n gates the write so a reset landing on the response cycle cannot commit the store
  assign ram_we  = (state_q == ST_RESP && wr_q && !bad_q && rst_n) ? bsel_q : 4'b0000;

  oldland_dbus_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .addr_i (ram_idx),
    .we_i   (ram_we),
    .wdata_i(wval_q),
    .rdata_o(ram_rdata)
  );

  assign load_word = ram_rdata & lane_mask(bsel_q);
  assign load_resp = (state_q == ST_RESP) && !wr_q && !bad_q;

  // RAM output is already registered, so the ack cycle shows it directly and data_q holds it afterwards
  assign bus_data  = load_resp ? load_word : data_q;
  assign bus_ack   = ack_q;
  assign bus_error = err_q;

  // Capture the request fields and verdict when it is accepted in IDLE
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && bus_access) begin
      idx_q  <= req_idx;
      bsel_q <= bus_bytesel;
      wr_q   <= bus_wr_en;
      wval_q <= bus_wr_val;
      bad_q  <= req_bad;
    end
  end

  // Request FSM with wait counter and registered response pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus_access) begin
            if (WAIT_STATES == 0) begin
              state_q <= ST_RESP;
              ack_q   <= !req_bad;
              err_q   <= req_bad;
            end else begin
              cnt_q   <= WS_LOAD;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            ack_q   <= !bad_q;
            err_q   <= bad_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          if (load_resp) data_q <= load_word;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_dbus_responder.sv
// tb/tb_oldland_dbus_responder.sv - scoreboard bench over three responders with 0, 3 and 5 wait states
module tb_oldland_dbus_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
  endfunction

  typedef struct {
    int          inst;
    logic        is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr [3];
  logic [3:0]  bsel [3];
  logic        wr   [3];
  logic [31:0] wval [3];
  logic        acc  [3];
  logic [31:0] data [3];
  logic        ack  [3];
  logic        err  [3];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [31:0] mem_m  [3][DEPTH];
  logic [31:0] last_d [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      oldland_dbus_responder #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(ws_of(g))
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr   (addr[g]),
        .bus_bytesel(bsel[g]),
        .bus_wr_en  (wr[g]),
        .bus_wr_val (wval[g]),
        .bus_access (acc[g]),
        .bus_data   (data[g]),
        .bus_ack    (ack[g]),
        .bus_error  (err[g])
      );
    end
  endgenerate

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pops one expectation per pulse and compares instance, verdict, timing and bus_data
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (ack[k] || err[k]) begin
          checkint($sformatf("ack_err_exclusive[%0d]", k), int'(ack[k] & err[k]), 0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_pulse inst=%0d actual=ack%b_err%b required=no_pulse", k, ack[k], err[k]);
          end else begin
            e = sb.pop_front();
            checkint("resp_inst", k, e.inst);
            checkint($sformatf("resp_error[%0d]", k), int'(err[k]), int'(e.is_err));
            checkint($sformatf("resp_cycle[%0d]", k), cyc, e.cyc);
            check32($sformatf("bus_data[%0d]", k), data[k], e.data);
          end
        end
      end
    end
  endtask

  // Drive one request, update the model, queue the expectation and wait for its pulse
  task automatic issue(input int k, input logic [31:0] a, input logic [3:0] b, input logic w,
                       input logic [31:0] v, input bit hold, input bit after_resp);
    logic        bad;
    logic [31:0] m;
    logic [31:0] off;
    int          idx;
    exp_t        e;
    bit          got;
    m   = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    off = a - BASE;
    bad = (off >= 32'(DEPTH * 4)) ||
          !(b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    idx = int'(off >> 2);
    if (!bad) begin
      if (w) mem_m[k][idx] = (mem_m[k][idx] & ~m) | (v & m);
      else   last_d[k]     = mem_m[k][idx] & m;
    end
    e.inst   = k;
    e.is_err = bad;
    e.data   = last_d[k];
    e.cyc    = cyc + 1 + ws_of(k) + (after_resp ? 1 : 0);
    sb.push_back(e);
    addr[k] = a;
    bsel[k] = b;
    wr[k]   = w;
    wval[k] = v;
    acc[k]  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = ack[k] | err[k];
    end
    checkint($sformatf("resp_seen[%0d]", k), int'(got), 1);
    if (!hold) begin
      acc[k] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; bsel[k] = '0; wr[k] = 1'b0; wval[k] = '0; acc[k] = 1'b0;
      last_d[k] = '0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check32($sformatf("reset_data[%0d]", k), data[k], 32'h0);
      checkint($sformatf("reset_ack[%0d]", k), int'(ack[k]), 0);
      checkint($sformatf("reset_err[%0d]", k), int'(err[k]), 0);
    end

    // Zero wait states: store then load the same word
    issue(0, BASE + 8,  4'b1111, 1'b1, 32'hDEADBEEF, 0, 0);
    issue(0, BASE + 8,  4'b1111, 1'b0, 32'h0,        0, 0);
    // Byte lanes
    issue(0, BASE + 12, 4'b1111, 1'b1, 32'h11223344, 0, 0);
    issue(0, BASE + 12, 4'b0100, 1'b1, 32'h00AA0000, 0, 0);
    issue(0, BASE + 12, 4'b1111, 1'b0, 32'h0,        0, 0);
    issue(0, BASE + 12, 4'b0011, 1'b0, 32'h0,        0, 0);
    issue(0, BASE + 12, 4'b1000, 1'b1, 32'h77000000, 0, 0);
    issue(0, BASE + 12, 4'b1100, 1'b0, 32'h0,        0, 0);
    // Edge words that an out-of-window store would alias onto
    issue(0, BASE + 0,  4'b1111, 1'b1, 32'h0A0B0C0D, 0, 0);
    issue(0, BASE + 60, 4'b1111, 1'b1, 32'hF0E0D0C0, 0, 0);
    // Rejected requests
    issue(0, BASE + 64, 4'b1111, 1'b1, 32'h99999999, 0, 0);
    issue(0, BASE - 4,  4'b1111, 1'b1, 32'h88888888, 0, 0);
    issue(0, BASE + 8,  4'b0101, 1'b1, 32'h77777777, 0, 0);
    issue(0, BASE + 8,  4'b0000, 1'b1, 32'h66666666, 0, 0);
    issue(0, BASE + 8,  4'b0110, 1'b0, 32'h0,        0, 0);
    issue(0, BASE + 8,  4'b1111, 1'b0, 32'h0,        0, 0);
    issue(0, BASE + 0,  4'b1111, 1'b0, 32'h0,        0, 0);
    issue(0, BASE + 60, 4'b1111, 1'b0, 32'h0,        0, 0);

    // Three wait states, including back-to-back requests with access held high
    issue(1, BASE + 4,  4'b1111, 1'b1, 32'h01234567, 0, 0);
    issue(1, BASE + 4,  4'b1111, 1'b0, 32'h0,        0, 0);
    issue(1, BASE + 20, 4'b1111, 1'b1, 32'hCAFEF00D, 1, 0);
    issue(1, BASE + 20, 4'b1111, 1'b0, 32'h0,        1, 1);
    issue(1, BASE + 20, 4'b0001, 1'b1, 32'h000000AB, 0, 1);
    issue(1, BASE + 20, 4'b1111, 1'b0, 32'h0,        0, 0);
    issue(1, BASE + 4,  4'b0010, 1'b0, 32'h0,        0, 0);

    // Five wait states with a reset landing in WAIT
    issue(2, BASE + 12, 4'b1111, 1'b1, 32'h5555AAAA, 0, 0);
    addr[2] = BASE + 12; bsel[2] = 4'b1111; wr[2] = 1'b1; wval[2] = 32'h12345678; acc[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n  = 1'b0;
    acc[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check32($sformatf("midreset_data[%0d]", k), data[k], 32'h0);
      checkint($sformatf("midreset_ack[%0d]", k), int'(ack[k]), 0);
      checkint($sformatf("midreset_err[%0d]", k), int'(err[k]), 0);
      last_d[k] = 32'h0;
    end
    repeat (8) @(negedge clk);
    issue(2, BASE + 12, 4'b1111, 1'b0, 32'h0,        0, 0);
    issue(2, BASE + 16, 4'b1111, 1'b1, 32'hA5A5C3C3, 1, 0);
    issue(2, BASE + 16, 4'b1100, 1'b0, 32'h0,        0, 1);

    repeat (10) @(negedge clk);
    checkint("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
